neuron_mac_seq: RTL

//  Sequencer and multiply-accumulate stage for one Simple NN neuron.
//  - Drives the 2-bit select of the upstream 4:1 x-operand mux:
//    x1, then x2, then constant 1 (bias).
//  - Consumes the selected 7-bit operand each cycle, multiplies it by the

---
 rtl/neuron_mac_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/neuron_mac_seq.sv
// Sequencer + multiply-accumulate for one neuron: steps the upstream x mux through
// x1, x2 and the bias constant, accumulates weight*x, and hands off sum + step activation.
module neuron_mac_seq #(
   parameter int XW   = 7,
   parameter int ACCW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XW-1:0]   w1,
   input  logic [XW-1:0]   w2,
   input  logic [XW-1:0]   wb,
   input  logic [XW-1:0]   x_in,
   output logic [1:0]      sel,
   output logic            busy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] y_sum,
   output logic            y_act
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_X1   = 3'd1,
      S_X2   = 3'd2,
      S_XB   = 3'd3,
      S_DONE = 3'd4
   } state_e;

   localparam int PW = 2 * XW;

   state_e            state_q, state_d;
   logic [XW-1:0]     w1_q, w1_d;
   logic [XW-1:0]     w2_q, w2_d;
   logic [XW-1:0]     wb_q, wb_d;
   logic [ACCW-1:0]   acc_q, acc_d;

   logic signed [XW-1:0] w_cur;
   logic signed [XW-1:0] x_cur;
   logic signed [PW-1:0] prod;
   logic [ACCW-1:0]      prod_ext;
   logic                 load;

   // Weight feeding the multiplier follows the operand the mux is currently returning.
   always_comb begin
      w_cur = '0;
      case (state_q)
         S_X1:    w_cur = $signed(w1_q);
         S_X2:    w_cur = $signed(w2_q);
         S_XB:    w_cur = $signed(wb_q);
         default: w_cur = '0;
      endcase
   end

   assign x_cur    = $signed(x_in);
   assign prod     = w_cur * x_cur;
   assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = S_X1;
            end
         end
         S_X1:   state_d = S_X2;
         S_X2:   state_d = S_XB;
         S_XB:   state_d = S_DONE;
         S_DONE: begin
            // start only counts once the current result has been taken.
            if (out_ready) begin
               if (start) begin
                  load    = 1'b1;
                  state_d = S_X1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w1_d  = w1_q;
      w2_d  = w2_q;
      wb_d  = wb_q;
      acc_d = acc_q;
      if (load) begin
         w1_d  = w1;
         w2_d  = w2;
         wb_d  = wb;
         acc_d = '0;
      end else if (state_q == S_X1 || state_q == S_X2 || state_q == S_XB) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         w1_q    <= '0;
         w2_q    <= '0;
         wb_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         wb_q    <= wb_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      sel = 2'b00;
      case (state_q)
         S_X2:    sel = 2'b01;
         S_XB:    sel = 2'b10;
         default: sel = 2'b00;
      endcase
   end

   assign busy      = (state_q == S_X1) || (state_q == S_X2) || (state_q == S_XB);
   assign out_valid = (state_q == S_DONE);
   assign y_sum     = acc_q;
   assign y_act     = ~acc_q[ACCW-1];

endmodule
